// File: rtl/sha_round_engine.sv
// sha_round_engine
// Two-rounds-per-cycle SHA-2 compression engine for SHA-256 and SHA-384/512.
// One block is compressed per accepted start. The engine owns the 16-word
// rolling message schedule, the a..h working variables and a copy of the
// chaining value, and adds the chaining value back in at the end.
// Ports:
//   clk, srst        clock, synchronous active-high reset
//   start            one-cycle request, honoured only when idle
//   hash_size        0 = SHA-256, 1 = SHA-384/512 (latched on start)
//   block_in[1023:0] message words W0..W15, word i at [64i+63:64i]
//   h_in[511:0]      chaining value H0..H7, word i at [64i+63:64i]
//   kt_even, kt_odd  round constants K[cnt], K[cnt+1] from zero-latency ROMs
//   cnt              even round index presented to both ROMs
//   rom_hash_size    latched hash_size, selects the ROM contents
//   busy             high from accepted start until done
//   done             one-cycle pulse, h_out valid
//   h_out[511:0]     updated chaining value, held until the next done
module sha_round_engine (
  input  logic          clk,
  input  logic          srst,
  input  logic          start,
  input  logic          hash_size,
  input  logic [1023:0] block_in,
  input  logic [511:0]  h_in,
  input  logic [63:0]   kt_even,
  input  logic [63:0]   kt_odd,
  output logic [6:0]    cnt,
  output logic          rom_hash_size,
  output logic          busy,
  output logic          done,
  output logic [511:0]  h_out
);

  localparam logic [1:0] ST_IDLE  = 2'd0;
  localparam logic [1:0] ST_ROUND = 2'd1;
  localparam logic [1:0] ST_FINAL = 2'd2;

  typedef logic [7:0][63:0]  wv_t;
  typedef logic [15:0][63:0] sched_t;

  logic [1:0] state_q, state_d;
  logic [6:0] cnt_q, cnt_d;
  logic       hs_q, hs_d;
  logic       busy_q, busy_d;
  logic       done_q, done_d;
  wv_t        hout_q, hout_d;
  wv_t        v_q, v_d;      // working variables, index 0 = a .. 7 = h
  wv_t        hc_q, hc_d;    // chaining value copy
  sched_t     w_q, w_d;      // W[t..t+15]
  wv_t        v_mid;
  logic [63:0] w_new0, w_new1;

  // SHA-256 lives in the low half of each lane; the upper half is kept zero.
  function automatic logic [63:0] lane(input logic [63:0] x, input logic hs);
    return hs ? x : {32'h0, x[31:0]};
  endfunction

  function automatic logic [63:0] rotr64(input logic [63:0] x, input int n);
    return (x >> n) | (x << (64 - n));
  endfunction

  function automatic logic [31:0] rotr32(input logic [31:0] x, input int n);
    return (x >> n) | (x << (32 - n));
  endfunction

  function automatic logic [63:0] bsig0(input logic [63:0] x, input logic hs);
    if (hs) return rotr64(x, 28) ^ rotr64(x, 34) ^ rotr64(x, 39);
    return {32'h0, rotr32(x[31:0], 2) ^ rotr32(x[31:0], 13) ^ rotr32(x[31:0], 22)};
  endfunction

  function automatic logic [63:0] bsig1(input logic [63:0] x, input logic hs);
    if (hs) return rotr64(x, 14) ^ rotr64(x, 18) ^ rotr64(x, 41);
    return {32'h0, rotr32(x[31:0], 6) ^ rotr32(x[31:0], 11) ^ rotr32(x[31:0], 25)};
  endfunction

  function automatic logic [63:0] ssig0(input logic [63:0] x, input logic hs);
    if (hs) return rotr64(x, 1) ^ rotr64(x, 8) ^ (x >> 7);
    return {32'h0, rotr32(x[31:0], 7) ^ rotr32(x[31:0], 18) ^ (x[31:0] >> 3)};
  endfunction

  function automatic logic [63:0] ssig1(input logic [63:0] x, input logic hs);
    if (hs) return rotr64(x, 19) ^ rotr64(x, 61) ^ (x >> 6);
    return {32'h0, rotr32(x[31:0], 17) ^ rotr32(x[31:0], 19) ^ (x[31:0] >> 10)};
  endfunction

  // One compression round; 64-bit wrap then lane mask gives mod 2^32 for SHA-256.
  function automatic wv_t one_round(input wv_t v, input logic [63:0] k,
                                    input logic [63:0] w, input logic hs);
    wv_t         r;
    logic [63:0] ch, maj, t1, t2;
    ch  = (v[4] & v[5]) ^ (~v[4] & v[6]);
    maj = (v[0] & v[1]) ^ (v[0] & v[2]) ^ (v[1] & v[2]);
    t1  = lane(v[7] + bsig1(v[4], hs) + ch + lane(k, hs) + w, hs);
    t2  = lane(bsig0(v[0], hs) + maj, hs);
    r[0] = lane(t1 + t2, hs);
    r[1] = v[0];
    r[2] = v[1];
    r[3] = v[2];
    r[4] = lane(v[3] + t1, hs);
    r[5] = v[4];
    r[6] = v[5];
    r[7] = v[6];
    return r;
  endfunction

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    hs_d    = hs_q;
    busy_d  = busy_q;
    done_d  = 1'b0;
    hout_d  = hout_q;
    v_d     = v_q;
    hc_d    = hc_q;
    w_d     = w_q;
    v_mid   = '0;
    // Both new schedule words come from the pre-shift window.
    w_new0  = lane(ssig1(w_q[14], hs_q) + w_q[9]  + ssig0(w_q[1], hs_q) + w_q[0], hs_q);
    w_new1  = lane(ssig1(w_q[15], hs_q) + w_q[10] + ssig0(w_q[2], hs_q) + w_q[1], hs_q);

    case (state_q)
      ST_IDLE: begin
        if (start) begin
          for (int i = 0; i < 16; i++) w_d[i] = lane(block_in[64*i +: 64], hash_size);
          for (int i = 0; i < 8; i++) begin
            v_d[i]  = lane(h_in[64*i +: 64], hash_size);
            hc_d[i] = lane(h_in[64*i +: 64], hash_size);
          end
          hs_d    = hash_size;
          cnt_d   = 7'd0;
          busy_d  = 1'b1;
          state_d = ST_ROUND;
        end
      end
      ST_ROUND: begin
        v_mid = one_round(v_q, kt_even, w_q[0], hs_q);
        v_d   = one_round(v_mid, kt_odd, w_q[1], hs_q);
        for (int i = 0; i < 14; i++) w_d[i] = w_q[i+2];
        w_d[14] = w_new0;
        w_d[15] = w_new1;
        if (cnt_q == (hs_q ? 7'd78 : 7'd62)) begin
          cnt_d   = 7'd0;
          state_d = ST_FINAL;
        end else begin
          cnt_d = cnt_q + 7'd2;
        end
      end
      ST_FINAL: begin
        for (int i = 0; i < 8; i++) hout_d[i] = lane(hc_q[i] + v_q[i], hs_q);
        done_d  = 1'b1;
        busy_d  = 1'b0;
        state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // Reset also clears data so an aborted block leaves nothing behind.
  always_ff @(posedge clk) begin
    if (srst) begin
      state_q <= ST_IDLE;
      cnt_q   <= '0;
      hs_q    <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      hout_q  <= '0;
      v_q     <= '0;
      hc_q    <= '0;
      w_q     <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      hs_q    <= hs_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
      hout_q  <= hout_d;
      v_q     <= v_d;
      hc_q    <= hc_d;
      w_q     <= w_d;
    end
  end

  assign cnt           = cnt_q;
  assign rom_hash_size = hs_q;
  assign busy          = busy_q;
  assign done          = done_q;
  assign h_out         = hout_q;

endmodule

// File: tb/tb_sha_round_engine.sv
// Testbench for sha_round_engine: known-answer vectors, constant sequencing,
// ignored start, two-block chaining, mid-block reset and random blocks against
// a behavioural SHA-2 reference model. Expected digests are queued at start and
// checked by an independent monitor when done pulses.
module tb_sha_round_engine;

  logic          clk = 1'b0;
  logic          srst, start, hash_size;
  logic [1023:0] block_in;
  logic [511:0]  h_in;
  logic [63:0]   kt_even, kt_odd;
  logic [6:0]    cnt;
  logic          rom_hash_size, busy, done;
  logic [511:0]  h_out;

  always #5 clk = ~clk;

  sha_round_engine dut (
    .clk(clk), .srst(srst), .start(start), .hash_size(hash_size),
    .block_in(block_in), .h_in(h_in), .kt_even(kt_even), .kt_odd(kt_odd),
    .cnt(cnt), .rom_hash_size(rom_hash_size), .busy(busy), .done(done),
    .h_out(h_out)
  );

  localparam logic [63:0] K512 [80] = '{
    64'h428a2f98d728ae22, 64'h7137449123ef65cd, 64'hb5c0fbcfec4d3b2f, 64'he9b5dba58189dbbc,
    64'h3956c25bf348b538, 64'h59f111f1b605d019, 64'h923f82a4af194f9b, 64'hab1c5ed5da6d8118,
    64'hd807aa98a3030242, 64'h12835b0145706fbe, 64'h243185be4ee4b28c, 64'h550c7dc3d5ffb4e2,
    64'h72be5d74f27b896f, 64'h80deb1fe3b1696b1, 64'h9bdc06a725c71235, 64'hc19bf174cf692694,
    64'he49b69c19ef14ad2, 64'hefbe4786384f25e3, 64'h0fc19dc68b8cd5b5, 64'h240ca1cc77ac9c65,
    64'h2de92c6f592b0275, 64'h4a7484aa6ea6e483, 64'h5cb0a9dcbd41fbd4, 64'h76f988da831153b5,
    64'h983e5152ee66dfab, 64'ha831c66d2db43210, 64'hb00327c898fb213f, 64'hbf597fc7beef0ee4,
    64'hc6e00bf33da88fc2, 64'hd5a79147930aa725, 64'h06ca6351e003826f, 64'h142929670a0e6e70,
    64'h27b70a8546d22ffc, 64'h2e1b21385c26c926, 64'h4d2c6dfc5ac42aed, 64'h53380d139d95b3df,
    64'h650a73548baf63de, 64'h766a0abb3c77b2a8, 64'h81c2c92e47edaee6, 64'h92722c851482353b,
    64'ha2bfe8a14cf10364, 64'ha81a664bbc423001, 64'hc24b8b70d0f89791, 64'hc76c51a30654be30,
    64'hd192e819d6ef5218, 64'hd69906245565a910, 64'hf40e35855771202a, 64'h106aa07032bbd1b8,
    64'h19a4c116b8d2d0c8, 64'h1e376c085141ab53, 64'h2748774cdf8eeb99, 64'h34b0bcb5e19b48a8,
    64'h391c0cb3c5c95a63, 64'h4ed8aa4ae3418acb, 64'h5b9cca4f7763e373, 64'h682e6ff3d6b2b8a3,
    64'h748f82ee5defb2fc, 64'h78a5636f43172f60, 64'h84c87814a1f0ab72, 64'h8cc702081a6439ec,
    64'h90befffa23631e28, 64'ha4506cebde82bde9, 64'hbef9a3f7b2c67915, 64'hc67178f2e372532b,
    64'hca273eceea26619c, 64'hd186b8c721c0c207, 64'heada7dd6cde0eb1e, 64'hf57d4f7fee6ed178,
    64'h06f067aa72176fba, 64'h0a637dc5a2c898a6, 64'h113f9804bef90dae, 64'h1b710b35131c471b,
    64'h28db77f523047d84, 64'h32caab7b40c72493, 64'h3c9ebe0a15c9bebc, 64'h431d67c49c100d4c,
    64'h4cc5d4becb3e42b6, 64'h597f299cfc657e2a, 64'h5fcb6fab3ad6faec, 64'h6c44198c4a475817
  };

  // Combinational round-constant ROMs; SHA-256 K is the top half of SHA-512 K.
  function automatic logic [63:0] kval(input logic [6:0] idx, input logic hs);
    logic [63:0] k;
    if (idx >= 7'd80) return 64'h0;
    k = K512[idx];
    return hs ? k : {32'h0, k[63:32]};
  endfunction

  assign kt_even = kval(cnt, rom_hash_size);
  assign kt_odd  = kval(cnt + 7'd1, rom_hash_size);

  // ---------------- reference model ----------------
  function automatic logic [31:0] ror32(input logic [31:0] x, input int n);
    return (x >> n) | (x << (32 - n));
  endfunction
  function automatic logic [63:0] ror64(input logic [63:0] x, input int n);
    return (x >> n) | (x << (64 - n));
  endfunction

  function automatic logic [511:0] model256(input logic [1023:0] blk, input logic [511:0] hin);
    logic [31:0] w [64];
    logic [31:0] hv [8];
    logic [31:0] a, b, c, d, e, f, g, h, t1, t2, kk;
    logic [63:0] kw;
    logic [511:0] r;
    for (int i = 0; i < 16; i++) w[i] = blk[64*i +: 32];
    for (int i = 16; i < 64; i++)
      w[i] = w[i-16] + (ror32(w[i-15], 7) ^ ror32(w[i-15], 18) ^ (w[i-15] >> 3))
           + w[i-7] + (ror32(w[i-2], 17) ^ ror32(w[i-2], 19) ^ (w[i-2] >> 10));
    for (int i = 0; i < 8; i++) hv[i] = hin[64*i +: 32];
    a = hv[0]; b = hv[1]; c = hv[2]; d = hv[3]; e = hv[4]; f = hv[5]; g = hv[6]; h = hv[7];
    for (int t = 0; t < 64; t++) begin
      kw = K512[t];
      kk = kw[63:32];
      t1 = h + (ror32(e, 6) ^ ror32(e, 11) ^ ror32(e, 25)) + ((e & f) ^ (~e & g)) + kk + w[t];
      t2 = (ror32(a, 2) ^ ror32(a, 13) ^ ror32(a, 22)) + ((a & b) ^ (a & c) ^ (b & c));
      h = g; g = f; f = e; e = d + t1; d = c; c = b; b = a; a = t1 + t2;
    end
    hv[0] += a; hv[1] += b; hv[2] += c; hv[3] += d;
    hv[4] += e; hv[5] += f; hv[6] += g; hv[7] += h;
    for (int i = 0; i < 8; i++) r[64*i +: 64] = {32'h0, hv[i]};
    return r;
  endfunction

  function automatic logic [511:0] model512(input logic [1023:0] blk, input logic [511:0] hin);
    logic [63:0] w [80];
    logic [63:0] hv [8];
    logic [63:0] a, b, c, d, e, f, g, h, t1, t2;
    logic [511:0] r;
    for (int i = 0; i < 16; i++) w[i] = blk[64*i +: 64];
    for (int i = 16; i < 80; i++)
      w[i] = w[i-16] + (ror64(w[i-15], 1) ^ ror64(w[i-15], 8) ^ (w[i-15] >> 7))
           + w[i-7] + (ror64(w[i-2], 19) ^ ror64(w[i-2], 61) ^ (w[i-2] >> 6));
    for (int i = 0; i < 8; i++) hv[i] = hin[64*i +: 64];
    a = hv[0]; b = hv[1]; c = hv[2]; d = hv[3]; e = hv[4]; f = hv[5]; g = hv[6]; h = hv[7];
    for (int t = 0; t < 80; t++) begin
      t1 = h + (ror64(e, 14) ^ ror64(e, 18) ^ ror64(e, 41)) + ((e & f) ^ (~e & g)) + K512[t] + w[t];
      t2 = (ror64(a, 28) ^ ror64(a, 34) ^ ror64(a, 39)) + ((a & b) ^ (a & c) ^ (b & c));
      h = g; g = f; f = e; e = d + t1; d = c; c = b; b = a; a = t1 + t2;
    end
    hv[0] += a; hv[1] += b; hv[2] += c; hv[3] += d;
    hv[4] += e; hv[5] += f; hv[6] += g; hv[7] += h;
    for (int i = 0; i < 8; i++) r[64*i +: 64] = hv[i];
    return r;
  endfunction

  // Big-endian digest text (H0 first) to lane layout.
  function automatic logic [511:0] mk256(input logic [255:0] dg);
    logic [511:0] r;
    for (int i = 0; i < 8; i++) r[64*i +: 64] = {32'h0, dg[255-32*i -: 32]};
    return r;
  endfunction
  function automatic logic [511:0] mk512(input logic [511:0] dg);
    logic [511:0] r;
    for (int i = 0; i < 8; i++) r[64*i +: 64] = dg[511-64*i -: 64];
    return r;
  endfunction

  // ---------------- scoreboard ----------------
  typedef struct {
    logic         hs;
    logic [511:0] dig;
    int           start_edge;
  } exp_t;

  exp_t exp_q [$];
  int   checks   = 0;
  int   failures = 0;
  int   cyc      = 0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic fail(input string name, input logic [511:0] act, input logic [511:0] req);
    failures++;
    $display("FAIL %s actual=%h required=%h", name, act, req);
  endtask

  task automatic chk(input string name, input logic [511:0] act, input logic [511:0] req);
    checks++;
    if (act !== req) fail(name, act, req);
  endtask

  // Monitor: digest, latency, done/busy relation, constant sequencing.
  initial begin : monitor
    exp_t e;
    logic busy_prev = 1'b0;
    logic done_prev = 1'b0;
    int   idx = 0;
    int   nrc;
    forever begin
      @(posedge clk);
      #1;
      if (done === 1'b1) begin
        chk("done_single_pulse", {511'h0, done_prev}, 512'h0);
        chk("busy_low_with_done", {511'h0, busy}, 512'h0);
        if (exp_q.size() == 0) begin
          checks++;
          fail("unexpected_done", h_out, 512'h0);
        end else begin
          e = exp_q.pop_front();
          chk("digest", h_out, e.dig);
          chk("latency", 512'(cyc - e.start_edge), 512'(e.hs ? 41 : 33));
        end
      end
      if (busy === 1'b1) begin
        if (!busy_prev) idx = 0;
        if (exp_q.size() > 0) begin
          nrc = exp_q[0].hs ? 40 : 32;
          chk("rom_hash_size_stable", {511'h0, rom_hash_size}, {511'h0, exp_q[0].hs});
          if (idx < nrc) chk("cnt_sequence", {505'h0, cnt}, 512'(2 * idx));
          else begin
            checks++;
            if (cnt > (exp_q[0].hs ? 7'd78 : 7'd62)) fail("cnt_past_last", {505'h0, cnt}, 512'h0);
          end
        end
        idx++;
      end
      busy_prev = busy;
      done_prev = done;
    end
  end

  // ---------------- driver ----------------
  task automatic wait_idle();
    int n = 0;
    while (busy !== 1'b0 && n < 200) begin @(negedge clk); n++; end
    if (n >= 200) begin checks++; fail("timeout_idle", {511'h0, busy}, 512'h0); end
  endtask

  task automatic wait_done();
    int n = 0;
    while (done !== 1'b1 && n < 100) begin @(negedge clk); n++; end
    if (n >= 100) begin checks++; fail("timeout_done", {511'h0, done}, 512'h1); end
  endtask

  task automatic drain();
    int n = 0;
    while ((exp_q.size() != 0 || busy !== 1'b0) && n < 200) begin @(negedge clk); n++; end
    if (n >= 200) begin checks++; fail("timeout_drain", 512'(exp_q.size()), 512'h0); end
  endtask

  function automatic logic [1023:0] rnd_blk();
    logic [1023:0] r;
    for (int i = 0; i < 32; i++) r[32*i +: 32] = $urandom();
    return r;
  endfunction

  function automatic logic [511:0] rnd_h();
    logic [511:0] r;
    for (int i = 0; i < 16; i++) r[32*i +: 32] = $urandom();
    return r;
  endfunction

  // Call at a negedge with the DUT idle. Inputs are scrambled afterwards to
  // prove the engine works from its latched copy.
  task automatic issue(input logic hs, input logic [1023:0] blk,
                       input logic [511:0] hin, input logic [511:0] dig);
    exp_t e;
    start = 1'b1; hash_size = hs; block_in = blk; h_in = hin;
    e.hs = hs; e.dig = dig; e.start_edge = cyc + 1;
    exp_q.push_back(e);
    @(negedge clk);
    start = 1'b0; hash_size = ~hs; block_in = rnd_blk(); h_in = rnd_h();
  endtask

  logic [511:0]  iv256, iv512, dig_abc256, dig_abc512, dig_2blk;
  logic [1023:0] blk_abc256, blk_abc512, blk1, blk2, rb;
  logic [511:0]  rh;
  logic          rhs;

  initial begin : stim
    iv256 = mk256(256'h6a09e667_bb67ae85_3c6ef372_a54ff53a_510e527f_9b05688c_1f83d9ab_5be0cd19);
    iv512 = mk512({64'h6a09e667f3bcc908, 64'hbb67ae8584caa73b, 64'h3c6ef372fe94f82b,
                   64'ha54ff53a5f1d36f1, 64'h510e527fade682d1, 64'h9b05688c2b3e6c1f,
                   64'h1f83d9abfb41bd6b, 64'h5be0cd19137e2179});
    dig_abc256 = mk256(256'hba7816bf_8f01cfea_414140de_5dae2223_b00361a3_96177a9c_b410ff61_f20015ad);
    dig_abc512 = mk512({64'hddaf35a193617aba, 64'hcc417349ae204131, 64'h12e6fa4e89a97ea2,
                        64'h0a9eeee64b55d39a, 64'h2192992a274fc1a8, 64'h36ba3c23a3feebbd,
                        64'h454d4423643ce80e, 64'h2a9ac94fa54ca49f});
    dig_2blk = mk256(256'h248d6a61_d20638b8_e5c02693_0c3e6039_a33ce459_64ff2167_f6ecedd4_19db06c1);

    blk_abc256 = '0; blk_abc256[31:0] = 32'h61626380; blk_abc256[64*15 +: 64] = 64'h18;
    blk_abc512 = '0; blk_abc512[63:0] = 64'h6162638000000000; blk_abc512[64*15 +: 64] = 64'h18;
    blk1 = '0;
    blk1[64*0  +: 32] = 32'h61626364; blk1[64*1  +: 32] = 32'h62636465;
    blk1[64*2  +: 32] = 32'h63646566; blk1[64*3  +: 32] = 32'h64656667;
    blk1[64*4  +: 32] = 32'h65666768; blk1[64*5  +: 32] = 32'h66676869;
    blk1[64*6  +: 32] = 32'h6768696a; blk1[64*7  +: 32] = 32'h68696a6b;
    blk1[64*8  +: 32] = 32'h696a6b6c; blk1[64*9  +: 32] = 32'h6a6b6c6d;
    blk1[64*10 +: 32] = 32'h6b6c6d6e; blk1[64*11 +: 32] = 32'h6c6d6e6f;
    blk1[64*12 +: 32] = 32'h6d6e6f70; blk1[64*13 +: 32] = 32'h6e6f7071;
    blk1[64*14 +: 32] = 32'h80000000;
    blk2 = '0; blk2[64*15 +: 32] = 32'h000001c0;

    srst = 1'b1; start = 1'b0; hash_size = 1'b0; block_in = '0; h_in = '0;
    repeat (3) @(negedge clk);
    srst = 1'b0;
    chk("reset_cnt", {505'h0, cnt}, 512'h0);
    chk("reset_rom_hash_size", {511'h0, rom_hash_size}, 512'h0);
    chk("reset_busy", {511'h0, busy}, 512'h0);
    chk("reset_done", {511'h0, done}, 512'h0);
    chk("reset_h_out", h_out, 512'h0);

    // Known-answer vectors.
    issue(1'b0, blk_abc256, iv256, dig_abc256); drain();
    issue(1'b1, blk_abc512, iv512, dig_abc512); drain();

    // Start while busy must be ignored.
    issue(1'b0, blk_abc256, iv256, dig_abc256);
    repeat (9) @(negedge clk);
    start = 1'b1; hash_size = 1'b1; block_in = rnd_blk(); h_in = rnd_h();
    @(negedge clk);
    start = 1'b0;
    drain();
    repeat (50) @(negedge clk);

    // Two-block message, chaining value fed back in the done cycle.
    issue(1'b0, blk1, iv256, model256(blk1, iv256));
    wait_done();
    issue(1'b0, blk2, h_out, dig_2blk);
    drain();

    // Mid-block reset: abort, then a clean run.
    issue(1'b1, rnd_blk(), iv512, 512'h0);
    repeat (14) @(negedge clk);
    srst = 1'b1;
    @(negedge clk);
    srst = 1'b0;
    exp_q.delete();
    chk("abort_busy", {511'h0, busy}, 512'h0);
    chk("abort_done", {511'h0, done}, 512'h0);
    chk("abort_h_out", h_out, 512'h0);
    chk("abort_cnt", {505'h0, cnt}, 512'h0);
    chk("abort_rom_hash_size", {511'h0, rom_hash_size}, 512'h0);
    repeat (45) @(negedge clk);
    wait_idle();
    issue(1'b0, blk_abc256, iv256, dig_abc256); drain();

    // Random blocks, back to back.
    for (int i = 0; i < 8; i++) begin
      rhs = 1'($urandom_range(0, 1));
      rb  = rnd_blk();
      rh  = rnd_h();
      if (i > 0) wait_done();
      wait_idle();
      issue(rhs, rb, rh, rhs ? model512(rb, rh) : model256(rb, rh));
    end
    drain();
    repeat (5) @(negedge clk);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin : watchdog
    #200000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1, "watchdog expired");
  end

endmodule

// File: doc/sha_round_engine.md
# sha_round_engine

Two-rounds-per-cycle SHA-2 compression engine. It is the consumer of the round-constant ROMs: it drives the round index and the hash-size select, and takes the even-round constant (stage-0 ROM) and the odd-round constant (stage-1 ROM) in the same cycle. It owns the 16-word message schedule and the a..h working variables, and it adds the chaining value back in. One 512-bit (SHA-256) or 1024-bit (SHA-384/512) block is compressed per start.

## Interface
Parameters: none. Widths are fixed by SHA-512; SHA-256 uses the low 32 bits of each 64-bit lane.

- clk  in  1  sole clock
- srst  in  1  synchronous, active-high reset
- start  in  1  single-cycle request; sampled only in IDLE
- hash_size  in  1  0 = SHA-256, 1 = SHA-384/512; latched on accepted start
- block_in  in  1024  W0..W15, word i at bits [64i+63:64i]; SHA-256 uses bits [64i+31:64i]
- h_in  in  512  chaining value H0..H7, word i at [64i+63:64i]; latched on start
- kt_even  in  64  constant K[cnt] from stage-0 ROM, combinational, same cycle
- kt_odd  in  64  constant K[cnt+1] from stage-1 ROM, combinational, same cycle
- cnt  out  7  even round index presented to both ROMs
- rom_hash_size  out  1  latched hash_size, drives both ROM selects
- busy  out  1  high from accepted start until done
- done  out  1  one-cycle pulse; h_out valid
- h_out  out  512  updated chaining value, held until the next done

## Operation
- States: IDLE, ROUND, FINAL.
- IDLE, start=1: latch W[0..15] from block_in, a..h from h_in, H copy from h_in, and hash_size. Set cnt=0, busy=1, go to ROUND. start while busy is ignored and has no effect.
- ROUND, each cycle: perform rounds t=cnt (using kt_even, W[0]) and t+1 (using kt_odd, W[1]) combinationally in series. Shift the schedule by two: W[0..13] <= W[2..15], and W[14], W[15] <= the next two schedule words from σ0/σ1 of the pre-shift window. Then cnt += 2.
- Last ROUND cycle: cnt=62 (SHA-256) or cnt=78 (SHA-512). Next state is FINAL. cnt does not advance past the last value and returns to 0 in FINAL.
- FINAL: h_out word i <= H[i] + working var i. Register done=1 and busy=0, then go to IDLE.
- Arithmetic:
  - SHA-256: all additions mod 2^32 per lane. Rotations use Σ0 = 2,13,22; Σ1 = 6,11,25; σ0 = 7,18,>>3; σ1 = 17,19,>>10. Upper 32 bits of every lane and of h_out words are forced to 0.
  - SHA-512: additions mod 2^64. Σ0 = 28,34,39; Σ1 = 14,18,41; σ0 = 1,8,>>7; σ1 = 19,61,>>6.
- Ch = (e&f)^(~e&g); Maj = (a&b)^(a&c)^(b&c).
- rom_hash_size is constant while busy, so the ROM output type cannot change mid-block.

## Timing
- Reset values: cnt=0, rom_hash_size=0, busy=0, done=0, h_out=0, state IDLE, schedule and working registers 0.
- srst mid-block: abort immediately into the reset values. No done is produced, and h_out returns to 0.
- Latency:
  - start sampled at edge E0.
  - ROUND edges run E1..E32 (SHA-256) or E1..E40 (SHA-512).
  - FINAL registers at E33 / E41, so done is high in the cycle after E33 / E41.
  - Start-to-done is 33 / 41 cycles.
- Throughput: start is accepted in the cycle done is high (state is IDLE then). Back-to-back blocks cost 34 / 42 cycles each, with no gap needed beyond that.
- Constant order: kt_even/kt_odd are consumed in the same cycle cnt is presented. The ROMs must be purely combinational with zero latency.
- busy falls in the same cycle done rises.

## Test plan
- SHA-256 "abc": padded block (W0=61626380, W15=00000018, rest 0), IV 6a09e667…5be0cd19 → done 33 cycles after start, h_out = ba7816bf 8f01cfea 414140de 5dae2223 b00361a3 96177a9c b410ff61 f20015ad, upper lane halves all 0.
- SHA-512 "abc": 1024-bit padded block (W0=6162638000000000, W15=0x18), IV 6a09e667f3bcc908… → done at 41 cycles, h_out = ddaf35a193617aba cc417349ae204131 12e6fa4e89a97ea2 0a9eeee64b55d39a 2192992a274fc1a8 36ba3c23a3feebbd 454d4423643ce80e 2a9ac94fa54ca49f.
- Constant sequencing: monitor cnt during SHA-512. It must read 0,2,…,78, one value per cycle, and rom_hash_size must stay 1. For SHA-256 it must stop at 62.
- Start while busy: pulse start at round 10 with different data → ignored; the result is the first block's digest, and only one done pulse occurs.
- Two-block SHA-256 ("abcdbcdecdef…nopq", 56 bytes): feed h_out back as h_in with start in the done cycle → final digest 248d6a61 d20638b8 e5c02693 0c3e6039 a33ce459 64ff2167 f6ecedd4 19db06c1.
- srst asserted at cycle 15 of a block → the next cycle has busy=0, done=0, h_out=0, cnt=0. A following "abc" run gives the correct digest.
